// File: rtl/manual_bp_sequencer.sv
// manual_bp_sequencer
// Steps the manual bad-point LUT reader in lockstep with the pixel raster.
// It flags pixels that match the current LUT coordinate and advances the list.
// At frame end it rewinds the list so entry 0 is presented for the next frame.
module manual_bp_sequencer #(
    parameter int WIDTH_BITS    = 10,
    parameter int HEIGHT_BITS   = 10,
    parameter int BAD_POINT_NUM = 128,
    parameter int BAD_POINT_BIT = 7,
    parameter int LUT_LAT       = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [WIDTH_BITS-1:0]    i_img_w,
    input  logic [HEIGHT_BITS-1:0]   i_img_h,
    input  logic [BAD_POINT_BIT-1:0] i_bad_point_num,
    input  logic                     i_s_valid,
    input  logic                     i_s_sof,
    input  logic [WIDTH_BITS-1:0]    i_width_bad,
    input  logic [HEIGHT_BITS-1:0]   i_height_bad,
    input  logic                     i_err_clr,
    output logic                     o_shift,
    output logic                     o_m_valid,
    output logic                     o_m_hit,
    output logic [BAD_POINT_BIT-1:0] o_hit_cnt,
    output logic                     o_miss_err,
    output logic                     o_sync_err
);

    // The issued counter must reach N+1 while rewinding the list
    localparam int         ISSUED_BITS = $clog2(BAD_POINT_NUM + 1);
    localparam logic [1:0] WAIT_INIT   = 2'(LUT_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        MATCH,
        WAIT,
        DONE,
        DRAIN
    } seqState_t;

    seqState_t                r_state;
    seqState_t                w_nextState;
    logic [WIDTH_BITS-1:0]    r_x;
    logic [WIDTH_BITS-1:0]    r_imgW;
    logic [WIDTH_BITS-1:0]    w_imgW;
    logic [WIDTH_BITS-1:0]    w_curX;
    logic [WIDTH_BITS-1:0]    w_posX;
    logic [HEIGHT_BITS-1:0]   r_y;
    logic [HEIGHT_BITS-1:0]   r_imgH;
    logic [HEIGHT_BITS-1:0]   w_imgH;
    logic [HEIGHT_BITS-1:0]   w_curY;
    logic [HEIGHT_BITS-1:0]   w_posY;
    logic [BAD_POINT_BIT-1:0] r_num;
    logic [BAD_POINT_BIT-1:0] w_num;
    logic [BAD_POINT_BIT-1:0] r_hitCnt;
    logic [ISSUED_BITS-1:0]   r_issued;
    logic [ISSUED_BITS-1:0]   w_issuedNext;
    logic [ISSUED_BITS-1:0]   w_numExt;
    logic [ISSUED_BITS-1:0]   w_drainTarget;
    logic [1:0]               r_waitCnt;
    logic                     r_mValid;
    logic                     r_mHit;
    logic                     r_missErr;
    logic                     r_syncErr;
    logic                     w_pixSof;
    logic                     w_sofAccept;
    logic                     w_lastCol;
    logic                     w_frameEnd;
    logic                     w_eq;
    logic                     w_before;
    logic                     w_compare;
    logic                     w_shift;
    logic                     w_hit;
    logic                     w_miss;
    logic                     w_sync;

    // Frame geometry and list length come from the inputs on the accepted first pixel
    assign w_pixSof    = i_s_valid & i_s_sof;
    assign w_sofAccept = w_pixSof && (r_state == IDLE);
    assign w_imgW      = w_sofAccept ? i_img_w : r_imgW;
    assign w_imgH      = w_sofAccept ? i_img_h : r_imgH;
    assign w_num       = w_sofAccept ? i_bad_point_num : r_num;
    assign w_numExt    = ISSUED_BITS'(w_num);
    assign w_drainTarget = ISSUED_BITS'(r_num) + ISSUED_BITS'(1);

    // The first pixel of a frame is always (0,0) regardless of the counters
    assign w_curX     = i_s_sof ? '0 : r_x;
    assign w_curY     = i_s_sof ? '0 : r_y;
    assign w_lastCol  = (w_curX == (w_imgW - WIDTH_BITS'(1)));
    assign w_frameEnd = i_s_valid && w_lastCol && (w_curY == (w_imgH - HEIGHT_BITS'(1)));

    // Without a pixel, the reference position is the next pixel still to come
    assign w_posX   = i_s_valid ? w_curX : r_x;
    assign w_posY   = i_s_valid ? w_curY : r_y;
    assign w_eq     = i_s_valid && (i_width_bad == w_curX) && (i_height_bad == w_curY);
    assign w_before = (i_height_bad < w_posY) ||
                      ((i_height_bad == w_posY) && (i_width_bad < w_posX));

    // Next-state, shift and hit/error strobes; the accepted first pixel is compared like MATCH
    always_comb begin
        w_nextState  = r_state;
        w_issuedNext = r_issued;
        w_compare    = 1'b0;
        w_shift      = 1'b0;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_sync       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_sofAccept) begin
                    w_issuedNext = '0;
                    if (i_bad_point_num == '0) begin
                        w_nextState = DONE;
                    end else begin
                        w_compare   = 1'b1;
                        w_nextState = MATCH;
                    end
                end
            end
            MATCH: begin
                if (w_pixSof) begin
                    w_sync      = 1'b1;
                    w_nextState = DRAIN;
                end else begin
                    w_compare = 1'b1;
                end
            end
            WAIT: begin
                if (w_pixSof) begin
                    w_sync      = 1'b1;
                    w_nextState = DRAIN;
                end else if (w_frameEnd) begin
                    w_nextState = DRAIN;
                end else if (r_waitCnt == 2'd0) begin
                    w_nextState = MATCH;
                end
            end
            DONE: begin
                if (w_pixSof) begin
                    w_sync      = 1'b1;
                    w_nextState = DRAIN;
                end else if (w_frameEnd) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                w_sync = w_pixSof;
                if (r_issued < w_drainTarget) begin
                    w_shift      = 1'b1;
                    w_issuedNext = r_issued + ISSUED_BITS'(1);
                    if (w_issuedNext == w_drainTarget) begin
                        w_nextState  = IDLE;
                        w_issuedNext = '0;
                    end
                end else begin
                    w_nextState  = IDLE;
                    w_issuedNext = '0;
                end
            end
            default: begin
                w_nextState  = IDLE;
                w_issuedNext = '0;
            end
        endcase

        if (w_compare) begin
            if (w_eq || w_before) begin
                w_shift      = 1'b1;
                w_hit        = w_eq;
                w_miss       = !w_eq;
                w_issuedNext = w_issuedNext + ISSUED_BITS'(1);
                w_nextState  = (w_issuedNext == w_numExt) ? DONE : WAIT;
            end else begin
                w_nextState = MATCH;
            end
            if (w_frameEnd) begin
                w_nextState = DRAIN;
            end
        end
    end

    // State register and count of shifts issued in this frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_issued <= '0;
        end else begin
            r_state  <= w_nextState;
            r_issued <= w_issuedNext;
        end
    end

    // LUT latency down-counter, loaded when entering WAIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_waitCnt <= 2'd0;
        end else if ((w_nextState == WAIT) && (r_state != WAIT)) begin
            r_waitCnt <= WAIT_INIT;
        end else if (r_waitCnt != 2'd0) begin
            r_waitCnt <= r_waitCnt - 2'd1;
        end
    end

    // Raster counters hold the coordinate of the next pixel
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_s_valid) begin
            if (w_lastCol) begin
                r_x <= '0;
                r_y <= w_frameEnd ? '0 : (w_curY + HEIGHT_BITS'(1));
            end else begin
                r_x <= w_curX + WIDTH_BITS'(1);
                r_y <= w_curY;
            end
        end
    end

    // Frame configuration captured on the accepted first pixel
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_imgW <= '0;
            r_imgH <= '0;
            r_num  <= '0;
        end else if (w_sofAccept) begin
            r_imgW <= i_img_w;
            r_imgH <= i_img_h;
            r_num  <= i_bad_point_num;
        end
    end

    // One-cycle output pipeline and per-frame hit counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mValid <= 1'b0;
            r_mHit   <= 1'b0;
            r_hitCnt <= '0;
        end else begin
            r_mValid <= i_s_valid;
            r_mHit   <= w_hit;
            if (w_sofAccept) begin
                r_hitCnt <= BAD_POINT_BIT'(w_hit);
            end else if (w_hit) begin
                r_hitCnt <= r_hitCnt + BAD_POINT_BIT'(1);
            end
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_missErr <= 1'b0;
            r_syncErr <= 1'b0;
        end else begin
            r_missErr <= w_miss | (r_missErr & ~i_err_clr);
            r_syncErr <= w_sync | (r_syncErr & ~i_err_clr);
        end
    end

    assign o_shift    = w_shift;
    assign o_m_valid  = r_mValid;
    assign o_m_hit    = r_mHit;
    assign o_hit_cnt  = r_hitCnt;
    assign o_miss_err = r_missErr;
    assign o_sync_err = r_syncErr;

endmodule

// File: tb/tb_manual_bp_sequencer.sv
// tb_manual_bp_sequencer
// Directed frames on an 8x4 image with a small behavioural LUT reader model.
module tb_manual_bp_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic [9:0]  imgW = 10'd8;
    logic [9:0]  imgH = 10'd4;
    logic [6:0]  badNum;
    logic        sValid;
    logic        sSof;
    logic        errClr;
    logic [9:0]  widthBad;
    logic [9:0]  heightBad;
    logic        shift;
    logic        mValid;
    logic        mHit;
    logic [6:0]  hitCnt;
    logic        missErr;
    logic        syncErr;

    logic [9:0]  lutX [8];
    logic [9:0]  lutY [8];
    logic [2:0]  lutIdx;
    int          shiftCount = 0;
    int          shiftBase  = 0;
    int          lastTag    = -1;
    logic [31:0] hitMask;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    manual_bp_sequencer dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_img_w        (imgW),
        .i_img_h        (imgH),
        .i_bad_point_num(badNum),
        .i_s_valid      (sValid),
        .i_s_sof        (sSof),
        .i_width_bad    (widthBad),
        .i_height_bad   (heightBad),
        .i_err_clr      (errClr),
        .o_shift        (shift),
        .o_m_valid      (mValid),
        .o_m_hit        (mHit),
        .o_hit_cnt      (hitCnt),
        .o_miss_err     (missErr),
        .o_sync_err     (syncErr)
    );

    // LUT reader model: entry k+1 appears one cycle after the k-th shift, wraps after N+1 shifts
    assign widthBad  = ({4'b0, lutIdx} < badNum) ? lutX[lutIdx] : 10'h3FF;
    assign heightBad = ({4'b0, lutIdx} < badNum) ? lutY[lutIdx] : 10'h3FF;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lutIdx <= 3'd0;
        end else if (shift) begin
            lutIdx     <= ({4'b0, lutIdx} == badNum) ? 3'd0 : lutIdx + 3'd1;
            shiftCount <= shiftCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One cycle of stimulus; also logs the hit result of the previous cycle's pixel
    task automatic applyStimulus(input logic v, input logic s, input int tag);
        @(negedge clk);
        if (lastTag >= 0 && mValid && mHit) hitMask[lastTag[4:0]] = 1'b1;
        lastTag = v ? tag : -1;
        sValid  = v;
        sSof    = s;
    endtask

    task automatic setList(input logic [6:0] n, input logic [9:0] x0, input logic [9:0] y0,
                           input logic [9:0] x1, input logic [9:0] y1,
                           input logic [9:0] x2, input logic [9:0] y2);
        badNum  = n;
        lutX[0] = x0; lutY[0] = y0;
        lutX[1] = x1; lutY[1] = y1;
        lutX[2] = x2; lutY[2] = y2;
    endtask

    task automatic runFrame(input int gap);
        hitMask   = 32'h0;
        shiftBase = shiftCount;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                applyStimulus(1'b1, (x == 0) && (y == 0), y * 8 + x);
                for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, -1);
            end
        end
        repeat (6) applyStimulus(1'b0, 1'b0, -1);
    endtask

    task automatic clearErrors();
        errClr = 1'b1;
        applyStimulus(1'b0, 1'b0, -1);
        errClr = 1'b0;
    endtask

    initial begin
        rstN    = 1'b0;
        sValid  = 1'b0;
        sSof    = 1'b0;
        errClr  = 1'b0;
        hitMask = 32'h0;
        setList(7'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        repeat (3) @(negedge clk);

        checkOutput("rst_shift",   shift,   32'h0);
        checkOutput("rst_mvalid",  mValid,  32'h0);
        checkOutput("rst_mhit",    mHit,    32'h0);
        checkOutput("rst_hitcnt",  hitCnt,  32'h0);
        checkOutput("rst_misserr", missErr, 32'h0);
        checkOutput("rst_syncerr", syncErr, 32'h0);
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, -1);

        // Basic frame: hits at (1,0),(5,1),(7,3), last one on the frame-end pixel
        setList(7'd3, 10'd1, 10'd0, 10'd5, 10'd1, 10'd7, 10'd3);
        runFrame(0);
        checkOutput("t1_hitmask", hitMask,                 32'h8000_2002);
        checkOutput("t1_hitcnt",  hitCnt,                  32'd3);
        checkOutput("t1_shifts",  shiftCount - shiftBase,  32'd4);
        checkOutput("t1_lutidx",  lutIdx,                  32'd0);
        checkOutput("t1_misserr", missErr,                 32'h0);

        // Adjacent points with back-to-back pixels: second one falls into WAIT and is missed
        setList(7'd2, 10'd2, 10'd0, 10'd3, 10'd0, 10'd0, 10'd0);
        runFrame(0);
        checkOutput("t2_hitmask", hitMask,                32'h0000_0004);
        checkOutput("t2_hitcnt",  hitCnt,                 32'd1);
        checkOutput("t2_misserr", missErr,                32'h1);
        checkOutput("t2_shifts",  shiftCount - shiftBase, 32'd3);
        checkOutput("t2_lutidx",  lutIdx,                 32'd0);
        clearErrors();
        checkOutput("t2_errclr",  missErr,                32'h0);

        // Same list with one idle cycle between pixels: both points hit
        runFrame(1);
        checkOutput("t2b_hitmask", hitMask,                32'h0000_000C);
        checkOutput("t2b_hitcnt",  hitCnt,                 32'd2);
        checkOutput("t2b_misserr", missErr,                32'h0);
        checkOutput("t2b_shifts",  shiftCount - shiftBase, 32'd3);

        // Unsorted list: (5,1) hits, (1,0) is already behind and gets skipped
        setList(7'd2, 10'd5, 10'd1, 10'd1, 10'd0, 10'd0, 10'd0);
        runFrame(0);
        checkOutput("t3_hitmask", hitMask, 32'h0000_2000);
        checkOutput("t3_hitcnt",  hitCnt,  32'd1);
        checkOutput("t3_misserr", missErr, 32'h1);
        clearErrors();

        // Empty list: no hits, a single rewind shift after the frame-end pixel
        setList(7'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        runFrame(0);
        checkOutput("t4_hitmask", hitMask,                32'h0);
        checkOutput("t4_hitcnt",  hitCnt,                 32'd0);
        checkOutput("t4_shifts",  shiftCount - shiftBase, 32'd1);
        checkOutput("t4_lutidx",  lutIdx,                 32'd0);

        // Frame aborted by a new first pixel at (3,1), then a normal frame
        setList(7'd3, 10'd1, 10'd0, 10'd5, 10'd1, 10'd7, 10'd3);
        hitMask   = 32'h0;
        shiftBase = shiftCount;
        applyStimulus(1'b1, 1'b1, 0);
        for (int t = 1; t <= 10; t++) applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b1, 1'b1, 0);
        repeat (6) applyStimulus(1'b0, 1'b0, -1);
        checkOutput("t5_syncerr", syncErr,                32'h1);
        checkOutput("t5_hitmask", hitMask,                32'h0000_0002);
        checkOutput("t5_shifts",  shiftCount - shiftBase, 32'd4);
        checkOutput("t5_lutidx",  lutIdx,                 32'd0);
        checkOutput("t5_hitcnt",  hitCnt,                 32'd1);
        runFrame(0);
        checkOutput("t5_next_hitmask", hitMask,                32'h8000_2002);
        checkOutput("t5_next_hitcnt",  hitCnt,                 32'd3);
        checkOutput("t5_next_shifts",  shiftCount - shiftBase, 32'd4);

        // Reset while waiting for the LUT after the (1,0) hit
        hitMask = 32'h0;
        applyStimulus(1'b1, 1'b1, 0);
        applyStimulus(1'b1, 1'b0, 1);
        @(negedge clk);
        rstN   = 1'b0;
        sValid = 1'b0;
        sSof   = 1'b0;
        #1;
        checkOutput("t6_mvalid",  mValid,  32'h0);
        checkOutput("t6_mhit",    mHit,    32'h0);
        checkOutput("t6_hitcnt",  hitCnt,  32'h0);
        checkOutput("t6_shift",   shift,   32'h0);
        checkOutput("t6_syncerr", syncErr, 32'h0);
        repeat (2) @(negedge clk);
        rstN    = 1'b1;
        lastTag = -1;
        applyStimulus(1'b0, 1'b0, -1);
        runFrame(0);
        checkOutput("t6_next_hitmask", hitMask,                32'h8000_2002);
        checkOutput("t6_next_hitcnt",  hitCnt,                 32'd3);
        checkOutput("t6_next_shifts",  shiftCount - shiftBase, 32'd4);
        checkOutput("t6_next_misserr", missErr,                32'h0);
        checkOutput("t6_next_syncerr", syncErr,                32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
